// File: rtl/ay8913_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ay8913_sched_pkg
//  Description : Shared constants and types for the AY-3-8913 write scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package ay8913_sched_pkg;

   // host write map
   localparam logic [3:0] c_addr_qaddr  = 4'h0;
   localparam logic [3:0] c_addr_qdata  = 4'h1;
   localparam logic [3:0] c_addr_direct = 4'h2;
   localparam logic [3:0] c_addr_ctrl   = 4'h3;
   localparam logic [3:0] c_addr_mark   = 4'h4;

   // host read map
   localparam logic [3:0] c_rd_status   = 4'h0;
   localparam logic [3:0] c_rd_count    = 4'h1;
   localparam logic [3:0] c_rd_frames   = 4'h2;
   localparam logic [3:0] c_rd_ctrl     = 4'h3;

   localparam int c_ctrl_enable = 0;
   localparam int c_ctrl_sync   = 1;
   localparam int c_ctrl_flush  = 2;

   localparam int c_entry_w        = 13;
   localparam int c_entry_mark_bit = 12;
   localparam int c_entry_reg_lsb  = 8;
   localparam int c_entry_data_lsb = 0;

   typedef struct packed {
      logic       mark;
      logic [3:0] regidx;
      logic [7:0] data;
   } sched_entry_t;

   typedef enum logic [0:0] {
      ST_WAIT  = 1'b0,
      ST_DRAIN = 1'b1
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/ay8913_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ay8913_cmd_fifo
//  Description : Synchronous first-word-fall-through FIFO for queued PSG writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module ay8913_cmd_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 13
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_pop_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
   localparam logic [c_ptr_w:0]   c_cnt_one  = (c_ptr_w + 1)'(1);
   localparam logic [c_ptr_w:0]   c_cnt_full = (c_ptr_w + 1)'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w:0]   r_count;
   logic               w_do_push;
   logic               w_do_pop;

   always_comb begin
      o_full     = (r_count == c_cnt_full);
      o_empty    = (r_count == '0);
      o_count    = r_count;
      o_pop_data = r_mem[r_rd_ptr];
      w_do_push  = i_push && !o_full;
      w_do_pop   = i_pop && !o_empty;
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/ay8913_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ay8913_write_scheduler
//  Description : Queues host register writes and drains them to the AY-3-8913,
//                immediately or in frame-synchronised batches.
//  Revision    : 1.0 - initial release
// ============================================================================
module ay8913_write_scheduler
   import ay8913_sched_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int FRAME_DIV  = 1280000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       host_write,
   input  logic [3:0] host_address,
   input  logic [7:0] host_data_in,
   output logic [7:0] host_data_out,
   output logic       psg_write,
   output logic [3:0] psg_register,
   output logic [7:0] psg_data,
   output logic       frame_tick
);

   localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
   localparam int c_div_w = $clog2(FRAME_DIV);
   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(FRAME_DIV - 1);
   localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);

   logic               r_enable;
   logic               r_sync;
   logic [3:0]         r_qaddr;
   logic [c_div_w-1:0] r_div;
   logic [7:0]         r_frames;
   logic               r_overflow;
   logic               r_overrun;
   sched_state_t       r_state;
   logic               r_psg_write;
   logic [3:0]         r_psg_register;
   logic [7:0]         r_psg_data;

   logic               w_wr_qaddr;
   logic               w_wr_qdata;
   logic               w_wr_direct;
   logic               w_wr_ctrl;
   logic               w_wr_mark;
   logic               w_flush;
   logic               w_tick;
   logic               w_push;
   logic               w_drain_slot;
   logic               w_pop;
   sched_entry_t       w_push_entry;
   sched_entry_t       w_head;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   logic [c_cnt_w-1:0] w_fifo_count;
   logic [4:0]         w_count5;

   always_comb begin
      w_wr_qaddr   = host_write && (host_address == c_addr_qaddr);
      w_wr_qdata   = host_write && (host_address == c_addr_qdata);
      w_wr_direct  = host_write && (host_address == c_addr_direct);
      w_wr_ctrl    = host_write && (host_address == c_addr_ctrl);
      w_wr_mark    = host_write && (host_address == c_addr_mark);
      w_flush      = w_wr_ctrl && host_data_in[c_ctrl_flush];
      w_tick       = r_enable && (r_div == c_div_last);
      w_push       = w_wr_qdata || w_wr_mark;
      w_push_entry = '0;
      if (w_wr_mark) begin
         w_push_entry.mark = 1'b1;
      end else begin
         w_push_entry.regidx = r_qaddr;
         w_push_entry.data   = host_data_in;
      end
      // in frame-sync mode the batch window opens on the tick itself
      w_drain_slot = r_sync && ((r_state == ST_DRAIN) || w_tick);
      w_pop        = r_enable && !w_flush && !w_wr_direct && !w_fifo_empty
                     && (!r_sync || w_drain_slot);
   end

   ay8913_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (c_entry_w)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (w_flush),
      .i_push      (w_push),
      .i_push_data (w_push_entry),
      .i_pop       (w_pop),
      .o_pop_data  (w_head),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty),
      .o_count     (w_fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_enable   <= 1'b0;
         r_sync     <= 1'b0;
         r_qaddr    <= 4'h0;
         r_div      <= '0;
         r_frames   <= 8'h00;
         r_overflow <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_wr_qaddr) r_qaddr <= host_data_in[3:0];
         if (w_wr_ctrl) begin
            r_enable <= host_data_in[c_ctrl_enable];
            r_sync   <= host_data_in[c_ctrl_sync];
         end
         if (!r_enable || w_tick) r_div <= '0;
         else                     r_div <= r_div + c_div_one;
         if (w_tick) r_frames <= r_frames + 8'h01;
         if (w_wr_ctrl) begin
            r_overflow <= 1'b0;
            r_overrun  <= 1'b0;
         end else begin
            if (w_push && w_fifo_full)         r_overflow <= 1'b1;
            if (w_tick && r_state == ST_DRAIN) r_overrun  <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_WAIT;
         r_psg_write    <= 1'b0;
         r_psg_register <= 4'h0;
         r_psg_data     <= 8'h00;
      end else begin
         if (!r_enable || w_flush || !r_sync) begin
            r_state <= ST_WAIT;
         end else if (w_drain_slot) begin
            if (w_wr_direct)                    r_state <= ST_DRAIN;
            else if (w_fifo_empty || w_head.mark) r_state <= ST_WAIT;
            else                                r_state <= ST_DRAIN;
         end
         r_psg_write <= w_wr_direct || (w_pop && !w_head.mark);
         if (w_wr_direct) begin
            r_psg_register <= r_qaddr;
            r_psg_data     <= host_data_in;
         end else if (w_pop && !w_head.mark) begin
            r_psg_register <= w_head.regidx;
            r_psg_data     <= w_head.data;
         end
      end
   end

   always_comb begin
      w_count5      = 5'(w_fifo_count);
      host_data_out = 8'h00;
      case (host_address)
         c_rd_status: host_data_out = {3'b000, r_overrun, r_overflow,
                                       (r_state == ST_DRAIN), w_fifo_full, w_fifo_empty};
         c_rd_count:  host_data_out = {3'b000, w_count5};
         c_rd_frames: host_data_out = r_frames;
         c_rd_ctrl:   host_data_out = {6'b000000, r_sync, r_enable};
         default:     host_data_out = 8'h00;
      endcase
   end

   assign psg_write    = r_psg_write;
   assign psg_register = r_psg_register;
   assign psg_data     = r_psg_data;
   assign frame_tick   = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_ay8913_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ay8913_write_scheduler
//  Description : Self-checking bench with a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ay8913_write_scheduler;

   localparam int FRAME_DIV  = 8;
   localparam int FIFO_DEPTH = 16;

   logic       clk;
   logic       rst;
   logic       host_write;
   logic [3:0] host_address;
   logic [7:0] host_data_in;
   logic [7:0] host_data_out;
   logic       psg_write;
   logic [3:0] psg_register;
   logic [7:0] psg_data;
   logic       frame_tick;

   int n_tests = 0;
   int n_fail  = 0;

   ay8913_write_scheduler #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .FRAME_DIV  (FRAME_DIV)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .host_write    (host_write),
      .host_address  (host_address),
      .host_data_in  (host_data_in),
      .host_data_out (host_data_out),
      .psg_write     (psg_write),
      .psg_register  (psg_register),
      .psg_data      (psg_data),
      .frame_tick    (frame_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   logic [12:0] m_q[$];
   logic        m_enable, m_sync, m_drain, m_ovf, m_ovr, m_pw;
   logic [3:0]  m_qaddr, m_pr;
   logic [7:0]  m_pd, m_frames;
   int          m_div;
   logic        t_tick, t_direct, t_ctrl, t_flush, t_push, t_full, t_pop, t_window, t_ovr_evt;
   logic [12:0] t_head;
   logic [11:0] obs[$];

   function automatic logic [7:0] m_read(input logic [3:0] a);
      case (a)
         4'h0: m_read = {3'b000, m_ovr, m_ovf, m_drain,
                         (m_q.size() == FIFO_DEPTH), (m_q.size() == 0)};
         4'h1: m_read = 8'(m_q.size());
         4'h2: m_read = m_frames;
         4'h3: m_read = {6'b000000, m_sync, m_enable};
         default: m_read = 8'h00;
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_q.delete();
         m_enable = 0; m_sync = 0; m_drain = 0; m_ovf = 0; m_ovr = 0; m_pw = 0;
         m_qaddr = 0; m_pr = 0; m_pd = 0; m_frames = 0; m_div = 0;
      end else begin
         t_tick    = m_enable && (m_div == FRAME_DIV - 1);
         t_direct  = host_write && (host_address == 4'h2);
         t_ctrl    = host_write && (host_address == 4'h3);
         t_flush   = t_ctrl && host_data_in[2];
         t_push    = host_write && (host_address == 4'h1 || host_address == 4'h4);
         t_full    = (m_q.size() == FIFO_DEPTH);
         t_ovr_evt = t_tick && m_drain;
         t_window  = !m_sync || m_drain || t_tick;
         t_pop     = 0;
         t_head    = 13'h0000;
         if (m_enable && !t_flush && !t_direct && t_window && m_q.size() != 0) begin
            t_pop  = 1;
            t_head = m_q.pop_front();
         end
         // a batch stays open only while it keeps issuing real data
         if (!m_enable || t_flush || !m_sync) m_drain = 0;
         else if (m_drain || t_tick)          m_drain = t_direct || (t_pop && !t_head[12]);
         m_pw = t_direct || (t_pop && !t_head[12]);
         if (t_direct)  {m_pr, m_pd} = {m_qaddr, host_data_in};
         else if (m_pw) {m_pr, m_pd} = t_head[11:0];
         if (t_push) begin
            if (t_full) m_ovf = 1;
            else m_q.push_back(host_address == 4'h4 ? 13'h1000 : {1'b0, m_qaddr, host_data_in});
         end
         if (t_flush) m_q.delete();
         if (t_ctrl) begin m_ovf = 0; m_ovr = 0; end
         else if (t_ovr_evt) m_ovr = 1;
         m_frames = m_frames + 8'(t_tick);
         m_div    = (!m_enable || t_tick) ? 0 : m_div + 1;
         if (t_ctrl) begin m_enable = host_data_in[0]; m_sync = host_data_in[1]; end
         if (host_write && host_address == 4'h0) m_qaddr = host_data_in[3:0];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("psg_write", 32'(psg_write), 32'(m_pw));
      check("psg_register", 32'(psg_register), 32'(m_pr));
      check("psg_data", 32'(psg_data), 32'(m_pd));
      check("frame_tick", 32'(frame_tick), 32'(m_enable && (m_div == FRAME_DIV - 1)));
      check("host_data_out", 32'(host_data_out), 32'(m_read(host_address)));
      if (psg_write === 1'b1) obs.push_back({psg_register, psg_data});
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic w, input logic [3:0] a, input logic [7:0] d);
      host_write   = w;
      host_address = a;
      host_data_in = d;
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 8'h00);
   endtask

   task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
      host_write   = 1'b0;
      host_address = a;
      #1;
      check(name, 32'(host_data_out), 32'(exp));
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      obs.delete();
   endtask

   task automatic wait_tick(input int max, input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         if (frame_tick === 1'b1) seen = 1'b1;
         else idle(1);
      end
      check(name, 32'(seen), 32'd1);
   endtask

   task automatic check_obs(input int idx, input logic [11:0] exp, input string name);
      if (idx < obs.size()) check(name, 32'(obs[idx]), 32'(exp));
      else check(name, 32'hDEAD, 32'(exp));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic [3:0] a;
      int         r;
      rst = 1'b1; host_write = 1'b0; host_address = 4'h0; host_data_in = 8'h00;

      // reset state
      do_reset();
      check("reset_psg_write", 32'(psg_write), 32'd0);
      rd(4'h0, 8'h01, "reset_status");
      rd(4'h1, 8'h00, "reset_count");
      rd(4'h2, 8'h00, "reset_frames");
      rd(4'h3, 8'h00, "reset_ctrl");

      // async drain
      drive(1, 4'h3, 8'h01);
      drive(1, 4'h0, 8'h07); drive(1, 4'h1, 8'h3E);
      drive(1, 4'h0, 8'h08); drive(1, 4'h1, 8'h0F);
      idle(6);
      check("async_n", 32'(obs.size()), 32'd2);
      check_obs(0, 12'h73E, "async_w0");
      check_obs(1, 12'h80F, "async_w1");
      rd(4'h1, 8'h00, "async_count");

      // frame sync batches
      do_reset();
      drive(1, 4'h0, 8'h00); drive(1, 4'h1, 8'h55);
      drive(1, 4'h0, 8'h01); drive(1, 4'h1, 8'h01);
      drive(1, 4'h4, 8'h00);
      drive(1, 4'h0, 8'h02); drive(1, 4'h1, 8'hAA);
      drive(1, 4'h3, 8'h03);
      check("sync_pre_n", 32'(obs.size()), 32'd0);
      wait_tick(20, "sync_tick1");
      idle(4);
      check("sync_batch1_n", 32'(obs.size()), 32'd2);
      check_obs(0, 12'h055, "sync_b1_w0");
      check_obs(1, 12'h101, "sync_b1_w1");
      rd(4'h2, 8'h01, "sync_frames1");
      rd(4'h0, 8'h00, "sync_status_wait");
      wait_tick(20, "sync_tick2");
      idle(3);
      check("sync_batch2_n", 32'(obs.size()), 32'd3);
      check_obs(2, 12'h2AA, "sync_b2_w0");
      rd(4'h2, 8'h02, "sync_frames2");
      rd(4'h0, 8'h01, "sync_status_end");

      // direct write arbitrated into an async drain
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         drive(1, 4'h0, 8'(i));
         drive(1, 4'h1, 8'(i * 17));
      end
      drive(1, 4'h0, 8'h0D);
      drive(1, 4'h3, 8'h01);
      idle(1);
      drive(1, 4'h2, 8'h09);
      idle(8);
      check("arb_n", 32'(obs.size()), 32'd5);
      check_obs(0, 12'h111, "arb_w0");
      check_obs(1, 12'hD09, "arb_direct");
      check_obs(2, 12'h222, "arb_w2");
      check_obs(3, 12'h333, "arb_w3");
      check_obs(4, 12'h444, "arb_w4");

      // full / overflow
      do_reset();
      for (int i = 0; i < 17; i++) drive(1, 4'h1, 8'(i));
      rd(4'h1, 8'h10, "full_count");
      rd(4'h0, 8'h0A, "full_status");
      check("model_full_count", 32'(m_q.size()), 32'd16);
      check("model_full_ovf", 32'(m_ovf), 32'd1);
      obs.delete();
      drive(1, 4'h3, 8'h01);
      idle(20);
      check("ovf_n", 32'(obs.size()), 32'd16);
      for (int i = 0; i < 16; i++) check_obs(i, 12'(i), "ovf_w");
      rd(4'h0, 8'h01, "ovf_status_cleared");

      // overrun then flush mid-drain
      do_reset();
      drive(1, 4'h0, 8'h05);
      for (int i = 0; i < 12; i++) drive(1, 4'h1, 8'(8'h80 + i));
      drive(1, 4'h3, 8'h03);
      wait_tick(20, "ovr_tick1");
      idle(1);
      wait_tick(20, "ovr_tick2");
      idle(1);
      rd(4'h0, 8'h14, "ovr_status");
      drive(1, 4'h3, 8'h07);
      obs.delete();
      idle(20);
      check("flush_no_writes", 32'(obs.size()), 32'd0);
      rd(4'h1, 8'h00, "flush_count");
      rd(4'h0, 8'h01, "flush_status");

      // reset mid-drain
      do_reset();
      drive(1, 4'h0, 8'h03);
      for (int i = 0; i < 8; i++) drive(1, 4'h1, 8'(i));
      drive(1, 4'h3, 8'h01);
      idle(2);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check("rst_psg_write", 32'(psg_write), 32'd0);
      obs.delete();
      for (int i = 0; i < 16; i++) begin
         check("rst_tick_silent", 32'(frame_tick), 32'd0);
         rd(4'(i), (i == 0) ? 8'h01 : 8'h00, "rst_read");
      end
      check("rst_no_writes", 32'(obs.size()), 32'd0);

      // randomized traffic against the model
      do_reset();
      for (int k = 0; k < 4000; k++) begin
         r = $urandom_range(0, 199);
         if (r == 0) begin
            rst = 1'b1; idle(1); rst = 1'b0;
         end else if (r < 80) begin
            drive(1'b0, 4'($urandom), 8'($urandom));
         end else begin
            r = $urandom_range(0, 99);
            if (r < 20)      a = 4'h0;
            else if (r < 50) a = 4'h1;
            else if (r < 60) a = 4'h2;
            else if (r < 68) a = 4'h3;
            else if (r < 82) a = 4'h4;
            else             a = 4'($urandom_range(5, 15));
            d = 8'($urandom);
            if (a == 4'h3) begin
               d[0] = ($urandom_range(0, 9) != 0);
               d[2] = ($urandom_range(0, 19) == 0);
            end
            drive(1'b1, a, d);
         end
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
